// File: rtl/fmul_arb_pkg.sv
// fmul_arb_pkg: definitions shared by the FP multiplier arbiter.
//   state_t      - arbiter FSM states (IDLE, EXEC, RESP)
//   EXC/OVF/UNF/ZER - bit positions inside the 4-bit response flag field
//   FP_W         - single-precision operand width
package fmul_arb_pkg;

    localparam int FP_W = 32;

    localparam int EXC = 3;
    localparam int OVF = 2;
    localparam int UNF = 1;
    localparam int ZER = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fmultiplication.sv
// fmultiplication: combinational single-precision multiplier datapath.
// Ports:
//   a, b       in  32  operands (IEEE-754 single layout)
//   result     out 32  product
//   exception  out 1   an operand has an all-ones exponent (result forced to 0)
//   overflow   out 1   biased exponent above range (result = signed infinity)
//   underflow  out 1   biased exponent below range (result = signed zero)
//   zero       out 1   product mantissa field is zero (result = signed zero)
// Behaviour note: zero is raised whenever the stored mantissa of the product is
// zero, so exact power-of-two products come back as a signed zero with zero=1.
module fmultiplication (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow,
    output logic        zero
);

    logic        sign;
    logic        normalised;
    logic        product_round;
    logic [23:0] operand_a;
    logic [23:0] operand_b;
    logic [47:0] product;
    logic [46:0] product_norm;
    logic [22:0] product_mantissa;
    logic [8:0]  sum_exponent;
    logic [8:0]  exponent;

    assign sign      = a[31] ^ b[31];
    assign exception = (&a[30:23]) | (&b[30:23]);

    // Hidden bit is 1 only for non-zero exponents.
    assign operand_a = {(|a[30:23]), a[22:0]};
    assign operand_b = {(|b[30:23]), b[22:0]};

    assign product    = {24'd0, operand_a} * {24'd0, operand_b};
    assign normalised = product[47];

    // Leading one is dropped: product_norm holds only the bits below it.
    assign product_norm = normalised ? product[46:0] : {product[45:0], 1'b0};

    assign product_round    = |product_norm[22:0];
    assign product_mantissa = product_norm[46:24] + {22'd0, (product_norm[23] & product_round)};

    // 9-bit arithmetic: bit 8 set means out of range, bit 7 tells which side.
    assign sum_exponent = {1'b0, a[30:23]} + {1'b0, b[30:23]};
    assign exponent     = sum_exponent - 9'd127 + {8'd0, normalised};

    assign overflow  = exponent[8] & ~exponent[7];
    assign underflow = exponent[8] & exponent[7];
    assign zero      = ~exception & ~overflow & ~underflow & (product_mantissa == 23'd0);

    always_comb begin
        result = {sign, exponent[7:0], product_mantissa};
        if (exception) begin
            result = 32'd0;
        end else if (overflow) begin
            result = {sign, 8'hFF, 23'd0};
        end else if (underflow || zero) begin
            result = {sign, 31'd0};
        end
    end

endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one fmultiplication among NUM_REQ clients.
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   req_valid/req_ready      per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b             packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready      response handshake
//   rsp_id, rsp_result, rsp_flags  requester index, product, {exc,ovf,unf,zero}
//   op_count                 accepted-response counter (only with FMUL_ARB_CNT_EN)
//   dbg_state                current FSM state (fmul_arb_pkg::state_t encoding)
// Optional feature macro: FMUL_ARB_CNT_EN adds the saturating op_count output.
//
// Handshake rules: a request transfers in the IDLE cycle where req_valid[i] and
// req_ready[i] are both high; a response transfers in the RESP cycle where
// rsp_valid and rsp_ready are both high. rsp_* stay stable while rsp_valid is
// high and rsp_ready is low; rsp_ready outside RESP has no effect.
module fmul_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [FP_W*NUM_REQ-1:0] req_a,
    input  logic [FP_W*NUM_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_result,
    output logic [3:0]              rsp_flags,
`ifdef FMUL_ARB_CNT_EN
    output logic [15:0]             op_count,
`endif
    output logic [1:0]              dbg_state
);

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [FP_W-1:0]     op_a_q;
    logic [FP_W-1:0]     op_b_q;
    logic [ID_W-1:0]     op_id_q;

    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W:0]       pick_sum;
    logic [FP_W-1:0]     sel_a;
    logic [FP_W-1:0]     sel_b;
    logic [NUM_REQ-1:0]  grant_vec;

    logic [FP_W-1:0]     mul_result;
    logic                mul_exc;
    logic                mul_ovf;
    logic                mul_unf;
    logic                mul_zero;
    logic [3:0]          mul_flags;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping at
    // NUM_REQ (not at 2^ID_W), so non-power-of-two NUM_REQ stays fair.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (pick_sum >= (ID_W+1)'(NUM_REQ)) begin
                pick_sum = pick_sum - (ID_W+1)'(NUM_REQ);
            end
            if (!pick_found && req_valid[pick_sum[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = pick_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                sel_a = req_a[i*FP_W +: FP_W];
                sel_b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_vec = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_vec[pick_id] = 1'b1;
                    state_d            = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst_n so req_ready reads 0 while reset is held, even though the
    // FSM sits in IDLE and requests may already be pending.
    assign req_ready = grant_vec & {NUM_REQ{rst_n}};
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = op_id_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_id_q    <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_found) begin
                op_a_q   <= sel_a;
                op_b_q   <= sel_b;
                op_id_q  <= pick_id;
                rr_ptr_q <= (pick_id == ID_W'(NUM_REQ-1)) ? '0 : pick_id + ID_W'(1);
            end
            if (state_q == EXEC) begin
                rsp_result <= mul_result;
                rsp_flags  <= mul_flags;
            end
        end
    end

    fmultiplication u_fmul (
        .a         (op_a_q),
        .b         (op_b_q),
        .result    (mul_result),
        .exception (mul_exc),
        .overflow  (mul_ovf),
        .underflow (mul_unf),
        .zero      (mul_zero)
    );

    always_comb begin
        mul_flags      = '0;
        mul_flags[EXC] = mul_exc;
        mul_flags[OVF] = mul_ovf;
        mul_flags[UNF] = mul_unf;
        mul_flags[ZER] = mul_zero;
    end

`ifdef FMUL_ARB_CNT_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else if (state_q == RESP && rsp_ready && op_cnt_q != 16'hFFFF) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: directed bench for fmul_arbiter (NUM_REQ = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 time
// units after it. Define FMUL_ARB_CNT_EN to also cover op_count.
module tb_fmul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_REQ-1:0]  req_valid = '0;
    logic [NUM_REQ-1:0]  req_ready;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_result;
    logic [3:0]          rsp_flags;
    logic [1:0]          dbg_state;
`ifdef FMUL_ARB_CNT_EN
    logic [15:0]         op_count;
`endif

    int checks = 0;
    int errors = 0;

    fmul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
`ifdef FMUL_ARB_CNT_EN
        .op_count   (op_count),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- driver ----------------
    // Presents one request, waits (bounded) for its grant and its response,
    // accepts the response and reports what was observed.
    task automatic issue_op(input int id, input logic [31:0] a, input logic [31:0] b,
                            output logic ok, output logic [3:0] gvec, output int lat,
                            output logic [31:0] res, output logic [3:0] flg,
                            output logic [ID_W-1:0] rid);
        ok = 1'b0; gvec = '0; lat = 0; res = '0; flg = '0; rid = '0;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_valid[id] = 1'b1;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (req_ready[id] === 1'b1) break;
            tick();
            #1;
        end
        gvec = req_ready;
        if (req_ready[id] !== 1'b1) begin
            req_valid[id] = 1'b0;
            return;
        end
        tick();
        req_valid[id] = 1'b0;
        lat = 1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (rsp_valid === 1'b1) break;
            tick();
            lat++;
        end
        if (rsp_valid !== 1'b1) return;
        res = rsp_result;
        flg = rsp_flags;
        rid = rsp_id;
        ok  = 1'b1;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
        checks++; if (rsp_flags !== 4'd0) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 0000", rsp_flags); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        req_valid = '0;
`ifdef FMUL_ARB_CNT_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
`endif
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic ok; logic [3:0] g; int lat; logic [31:0] r; logic [3:0] f; logic [ID_W-1:0] id;
        issue_op(1, 32'h40000000, 32'h40400000, ok, g, lat, r, f, id);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", ok); end
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", g); end
        checks++; if (lat != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
        checks++; if (id !== 2'd1) begin errors++; $display("FAIL single_id: got %0d expected 1", id); end
        checks++; if (r !== 32'h40C00000) begin errors++; $display("FAIL single_result: got %h expected 40c00000", r); end
        checks++; if (f !== 4'b0000) begin errors++; $display("FAIL single_flags: got %b expected 0000", f); end
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", rsp_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0]      exp_vec;
        logic [ID_W-1:0] exp_id;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*32 +: 32] = 32'h3FC00000;
            req_b[i*32 +: 32] = 32'h3FC00000;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id  = 2'(k % 4);
            exp_vec = 4'b0001 << exp_id;
            #1;
            checks++; if (req_ready !== exp_vec) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_vec); end
            tick();
            #1;
            checks++; if ({rsp_valid, req_ready} !== 5'b0) begin errors++; $display("FAIL rr_exec[%0d]: got valid=%b ready=%b expected 0/0000", k, rsp_valid, req_ready); end
            tick();
            #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected 1", k, rsp_valid); end
            checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", k, rsp_id, exp_id); end
            checks++; if ({rsp_flags, rsp_result} !== {4'b0000, 32'h40100000}) begin errors++; $display("FAIL rr_result[%0d]: got %b/%h expected 0000/40100000", k, rsp_flags, rsp_result); end
            if (k == 4) req_valid = '0;
            tick();
        end
        // rsp_ready still high with nothing in flight: must be ignored.
        tick();
        #1;
        checks++; if ({dbg_state, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rr_idle_ignore_ready: got state=%0d valid=%b expected 0/0", dbg_state, rsp_valid); end
        rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_flags();
        logic [31:0] fa[5];
        logic [31:0] fb[5];
        logic [31:0] fr[5];
        logic [3:0]  ff[5];
        logic ok; logic [3:0] g; int lat; logic [31:0] r; logic [3:0] f; logic [ID_W-1:0] id;
        fa = '{32'h7F800000, 32'h7F000000, 32'h00800000, 32'h00000000, 32'hC0000000};
        fb = '{32'h3F800000, 32'h7F000000, 32'h00800000, 32'h40400000, 32'h40000000};
        fr = '{32'h00000000, 32'h7F800000, 32'h00000000, 32'h00000000, 32'h80000000};
        ff = '{4'b1000,      4'b0100,      4'b0010,      4'b0001,      4'b0001};
        for (int k = 0; k < 5; k++) begin
            issue_op(k % 4, fa[k], fb[k], ok, g, lat, r, f, id);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flags_done[%0d]: got %b expected 1", k, ok); end
            checks++; if (r !== fr[k]) begin errors++; $display("FAIL flags_result[%0d]: got %h expected %h", k, r, fr[k]); end
            checks++; if (f !== ff[k]) begin errors++; $display("FAIL flags_flags[%0d]: got %b expected %b", k, f, ff[k]); end
            checks++; if (id !== 2'(k % 4)) begin errors++; $display("FAIL flags_id[%0d]: got %0d expected %0d", k, id, k % 4); end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_a[0 +: 32]  = 32'h3FC00000;
        req_b[0 +: 32]  = 32'h3FC00000;
        req_a[64 +: 32] = 32'h40000000;
        req_b[64 +: 32] = 32'h40400000;
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant: got %b expected 0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        tick();
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, 2'd0, 4'b0000, 32'h40100000}) begin
            errors++; $display("FAIL bp_first_rsp: got valid=%b id=%0d flags=%b result=%h expected 1/0/0000/40100000", rsp_valid, rsp_id, rsp_flags, rsp_result);
        end
        for (int n = 0; n < 5; n++) begin
            tick();
            #1;
            checks++; if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, 2'd0, 4'b0000, 32'h40100000}) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid=%b id=%0d flags=%b result=%h expected 1/0/0000/40100000", n, rsp_valid, rsp_id, rsp_flags, rsp_result);
            end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant[%0d]: got %b expected 0000", n, req_ready); end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        checks++; if ({dbg_state, rsp_valid} !== 3'b000) begin errors++; $display("FAIL bp_release: got state=%0d valid=%b expected 0/0", dbg_state, rsp_valid); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0;
        tick();
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd2, 32'h40C00000}) begin
            errors++; $display("FAIL bp_second_rsp: got valid=%b id=%0d result=%h expected 1/2/40c00000", rsp_valid, rsp_id, rsp_result);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic ok; logic [3:0] g; int lat; logic [31:0] r; logic [3:0] f; logic [ID_W-1:0] id;
        // Pointer is at 3 after the previous test, so requester 3 wins first.
        req_a[96 +: 32] = 32'h40000000;
        req_b[96 +: 32] = 32'h40400000;
        req_a[32 +: 32] = 32'h3FC00000;
        req_b[32 +: 32] = 32'h3FC00000;
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_grant: got %b expected 1000", req_ready); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== 39'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got valid=%b id=%0d flags=%b result=%h expected all 0", rsp_valid, rsp_id, rsp_flags, rsp_result);
        end
        checks++; if ({dbg_state, req_ready} !== 6'd0) begin errors++; $display("FAIL mid_reset_state: got state=%0d ready=%b expected 0/0000", dbg_state, req_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_response: got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_post_grant: got %b expected 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        tick();
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 32'h40100000}) begin
            errors++; $display("FAIL mid_post_rsp: got valid=%b id=%0d result=%h expected 1/1/40100000", rsp_valid, rsp_id, rsp_result);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue_op(3, 32'h40000000, 32'h40400000, ok, g, lat, r, f, id);
        checks++; if ({ok, id, r} !== {1'b1, 2'd3, 32'h40C00000}) begin
            errors++; $display("FAIL mid_drain: got ok=%b id=%0d result=%h expected 1/3/40c00000", ok, id, r);
        end
    endtask

`ifdef FMUL_ARB_CNT_EN
    task automatic test_counter();
        logic ok; logic [3:0] g; int lat; logic [31:0] r; logic [3:0] f; logic [ID_W-1:0] id;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            issue_op(k % 4, 32'h40000000, 32'h40400000, ok, g, lat, r, f, id);
        end
        #1;
        checks++; if (op_count !== 16'd10) begin errors++; $display("FAIL cnt_ten: got %0d expected 10", op_count); end
        tick();
        force dut.op_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        tick();
        issue_op(0, 32'h40000000, 32'h40400000, ok, g, lat, r, f, id);
        #1;
        checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate: got %h expected ffff", op_count); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flags();
        test_backpressure();
        test_reset_mid_op();
`ifdef FMUL_ARB_CNT_EN
        test_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
